// File: rtl/core_run_ctrl_if.sv
// ---------------------------------------------------------------------------
// core_run_ctrl_if
// Boot-load word stream between an image source and the run controller.
//
// Signals:
//   ld_valid  source has a word on ld_data
//   ld_ready  controller accepts the word this cycle
//   ld_data   32-bit instruction word
//   ld_last   final word of the image
//
// Modports:
//   master  image source (drives valid/data/last)
//   slave   run controller (drives ready)
// ---------------------------------------------------------------------------
interface core_run_ctrl_if;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_data;
    logic        ld_last;

    modport master (output ld_valid, output ld_data, output ld_last, input ld_ready);
    modport slave  (input ld_valid, input ld_data, input ld_last, output ld_ready);
endinterface

// File: rtl/core_run_ctrl.sv
// ---------------------------------------------------------------------------
// core_run_ctrl
// Run controller for the single-cycle RISC-V core. After reset it holds the
// core in reset while an image is streamed into instruction memory, releases
// the core for one cycle of reset with a complete image, then runs it until
// an EBREAK, an external halt request or (optionally) the watchdog stops it.
// From HALT it can single-step, resume or reload. core_en gates every piece
// of architectural state in the core, so the core freezes whenever it is 0.
//
// Optional build macro: CORE_WDT_EN enables the RUN-cycle watchdog.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   ld             boot-load stream (slave side of core_run_ctrl_if)
//   imem_we        imem write strobe
//   imem_waddr     imem word address
//   imem_wdata     imem write data
//   instr          instruction currently fetched by the core
//   core_rst       reset to pc/core
//   core_en        core advance/commit enable
//   run_req        resume from HALT (pulse)
//   step_req       execute one instruction from HALT (pulse)
//   halt_req       halt from RUN (pulse)
//   reload_req     return to LOAD from HALT (pulse)
//   state          LOAD=0 RELEASE=1 RUN=2 STEP=3 HALT=4
//   halt_cause     0 none, 1 ebreak, 2 halt_req, 3 watchdog
//   instret        count of cycles with core_en=1 (wraps)
// ---------------------------------------------------------------------------
module core_run_ctrl #(
    parameter int          ADDR_W      = 8,
    parameter int          WDT_CYCLES  = 100000,
    parameter logic [31:0] EBREAK_INSN = 32'h00100073
) (
    input  logic              clk,
    input  logic              rst,
    core_run_ctrl_if.slave    ld,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    input  logic [31:0]       instr,
    output logic              core_rst,
    output logic              core_en,
    input  logic              run_req,
    input  logic              step_req,
    input  logic              halt_req,
    input  logic              reload_req,
    output logic [2:0]        state,
    output logic [1:0]        halt_cause,
    output logic [31:0]       instret
);

    localparam logic [2:0] ST_LOAD    = 3'd0;
    localparam logic [2:0] ST_RELEASE = 3'd1;
    localparam logic [2:0] ST_RUN     = 3'd2;
    localparam logic [2:0] ST_STEP    = 3'd3;
    localparam logic [2:0] ST_HALT    = 3'd4;

    localparam logic [1:0] CAUSE_NONE   = 2'd0;
    localparam logic [1:0] CAUSE_EBREAK = 2'd1;
    localparam logic [1:0] CAUSE_HALT   = 2'd2;
    localparam logic [1:0] CAUSE_WDT    = 2'd3;

    logic [2:0]        state_q;
    logic [2:0]        state_d;
    logic [1:0]        cause_q;
    logic [1:0]        cause_d;
    logic [ADDR_W-1:0] addr_q;
    logic              skip_q;
    logic [31:0]       instret_q;
    logic              ebreak_hit;
    logic              wdt_hit;
    logic              load_done;

    // skip lets a resumed RUN commit the EBREAK it halted on
    assign ebreak_hit = (instr == EBREAK_INSN) && !skip_q;

    // the last word or the top address both close the image
    assign load_done  = imem_we && (ld.ld_last || (addr_q == {ADDR_W{1'b1}}));

`ifdef CORE_WDT_EN
    logic [31:0] wdt_q;

    assign wdt_hit = (state_q == ST_RUN) && (wdt_q == 32'(WDT_CYCLES - 1));

    // Counts consecutive RUN cycles; restarts on every entry to RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_q <= 32'd0;
        end else if ((state_q != ST_RUN) && (state_d == ST_RUN)) begin
            wdt_q <= 32'd0;
        end else if (state_q == ST_RUN) begin
            wdt_q <= wdt_q + 32'd1;
        end
    end
`else
    assign wdt_hit = 1'b0;
`endif

    // Load-side handshake and imem write port.
    always_comb begin
        ld.ld_ready = (state_q == ST_LOAD);
        imem_we     = ld.ld_valid && (state_q == ST_LOAD);
        imem_waddr  = addr_q;
        imem_wdata  = ld.ld_data;
    end

    // Core control: EBREAK and halt_req block the commit in the same cycle
    // they are seen, so the PC stays on the halting instruction.
    always_comb begin
        core_rst = (state_q == ST_LOAD) || (state_q == ST_RELEASE);
        core_en  = 1'b0;
        case (state_q)
            ST_RUN:  core_en = !ebreak_hit && !halt_req && !wdt_hit;
            ST_STEP: core_en = 1'b1;
            default: core_en = 1'b0;
        endcase
    end

    // Next-state and halt-cause selection.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            ST_LOAD: begin
                if (load_done) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_d = ST_RUN;
                cause_d = CAUSE_NONE;
            end
            ST_RUN: begin
                if (ebreak_hit) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_EBREAK;
                end else if (halt_req) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_HALT;
                end else if (wdt_hit) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_WDT;
                end
            end
            ST_STEP: begin
                state_d = ST_HALT;
            end
            ST_HALT: begin
                if (reload_req) begin
                    state_d = ST_LOAD;
                    cause_d = CAUSE_NONE;
                end else if (step_req) begin
                    state_d = ST_STEP;
                end else if (run_req) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_LOAD;
                cause_d = CAUSE_NONE;
            end
        endcase
    end

    // State, cause, load address, skip flag and retired-instruction count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_LOAD;
            cause_q   <= CAUSE_NONE;
            addr_q    <= '0;
            skip_q    <= 1'b0;
            instret_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;

            if ((state_q == ST_HALT) && reload_req) begin
                addr_q <= '0;
            end else if (imem_we) begin
                addr_q <= addr_q + 1'b1;
            end

            if ((state_q == ST_HALT) && (state_d == ST_RUN)) begin
                skip_q <= 1'b1;
            end else if (state_q == ST_RUN) begin
                skip_q <= 1'b0;
            end

            if (core_en) begin
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    assign state      = state_q;
    assign halt_cause = cause_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_core_run_ctrl
// Directed bench for core_run_ctrl. A tiny behavioural core (addi, jal,
// everything else treated as pc+4) fetches from a bench-side imem that the
// controller writes, so halting, stepping and resuming are visible through
// the PC and register file as well as the controller outputs.
// ---------------------------------------------------------------------------
module tb_core_run_ctrl;

    localparam logic [31:0] I_ADDI1  = 32'h00500093; // addi x1,x0,5
    localparam logic [31:0] I_ADDI2  = 32'h00308113; // addi x2,x1,3
    localparam logic [31:0] I_EBREAK = 32'h00100073;
    localparam logic [31:0] I_NOP    = 32'h00000013;
    localparam logic [31:0] I_JAL0   = 32'h0000006F; // jal x0,0

    logic        clk;
    logic        rst;
    logic        imem_we;
    logic [7:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic [31:0] instr;
    logic        core_rst;
    logic        core_en;
    logic        run_req;
    logic        step_req;
    logic        halt_req;
    logic        reload_req;
    logic [2:0]  state;
    logic [1:0]  halt_cause;
    logic [31:0] instret;

    int vectors;
    int miscompares;

    core_run_ctrl_if ld_bus ();

    core_run_ctrl #(
        .ADDR_W      (8),
        .WDT_CYCLES  (16),
        .EBREAK_INSN (32'h00100073)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ld         (ld_bus.slave),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .instr      (instr),
        .core_rst   (core_rst),
        .core_en    (core_en),
        .run_req    (run_req),
        .step_req   (step_req),
        .halt_req   (halt_req),
        .reload_req (reload_req),
        .state      (state),
        .halt_cause (halt_cause),
        .instret    (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural core and instruction memory
    logic [31:0] imem [0:255];
    logic [31:0] xreg [0:31];
    logic [31:0] pc;

    assign instr = imem[pc[9:2]];

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = I_NOP;
        for (int i = 0; i < 32; i++) xreg[i] = 32'd0;
        pc = 32'd0;
    end

    always @(posedge clk) begin
        if (imem_we) imem[imem_waddr] <= imem_wdata;
        if (core_rst) begin
            pc <= 32'd0;
        end else if (core_en) begin
            if (instr[6:0] == 7'h13) begin
                if (instr[11:7] != 5'd0)
                    xreg[instr[11:7]] <= xreg[instr[19:15]] + {{20{instr[31]}}, instr[31:20]};
                pc <= pc + 32'd4;
            end else if (instr[6:0] == 7'h6F) begin
                pc <= pc + {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            end else begin
                pc <= pc + 32'd4;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // req = {reload, step, halt, run}
    task automatic applyStimulus(input logic valid, input logic [31:0] data, input logic last, input logic [3:0] req);
        ld_bus.ld_valid = valid;
        ld_bus.ld_data  = data;
        ld_bus.ld_last  = last;
        reload_req      = req[3];
        step_req        = req[2];
        halt_req        = req[1];
        run_req         = req[0];
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic loadWord(input logic [31:0] data, input logic last, input logic [7:0] exp_addr, input string tag);
        applyStimulus(1'b1, data, last, 4'b0000);
        checkOutput({tag, "_we"}, {31'd0, imem_we}, 32'd1);
        checkOutput({tag, "_addr"}, {24'd0, imem_waddr}, {24'd0, exp_addr});
        nextCycle();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        applyStimulus(1'b0, 32'd0, 1'b0, 4'b0000);
        @(negedge clk);

        // reset state
        checkOutput("rst_state", {29'd0, state}, 32'd0);
        checkOutput("rst_core_rst", {31'd0, core_rst}, 32'd1);
        checkOutput("rst_core_en", {31'd0, core_en}, 32'd0);
        checkOutput("rst_ld_ready", {31'd0, ld_bus.ld_ready}, 32'd1);
        checkOutput("rst_cause", {30'd0, halt_cause}, 32'd0);
        checkOutput("rst_instret", instret, 32'd0);
        rst = 1'b0;

        // boot image with a 3-cycle gap after word 1
        loadWord(I_ADDI1, 1'b0, 8'd0, "ld0");
        loadWord(I_ADDI2, 1'b0, 8'd1, "ld1");
        for (int g = 0; g < 3; g++) begin
            applyStimulus(1'b0, 32'hDEADBEEF, 1'b0, 4'b0000);
            checkOutput("gap_we", {31'd0, imem_we}, 32'd0);
            nextCycle();
        end
        loadWord(I_EBREAK, 1'b0, 8'd2, "ld2");
        loadWord(I_NOP, 1'b1, 8'd3, "ld3");
        applyStimulus(1'b0, 32'd0, 1'b0, 4'b0000);
        checkOutput("rel_state", {29'd0, state}, 32'd1);
        checkOutput("rel_core_rst", {31'd0, core_rst}, 32'd1);
        checkOutput("rel_ld_ready", {31'd0, ld_bus.ld_ready}, 32'd0);
        checkOutput("rel_core_en", {31'd0, core_en}, 32'd0);
        nextCycle();
        checkOutput("run_state", {29'd0, state}, 32'd2);
        checkOutput("run_core_rst", {31'd0, core_rst}, 32'd0);
        checkOutput("run_core_en", {31'd0, core_en}, 32'd1);
        nextCycle();
        checkOutput("run_instret1", instret, 32'd1);
        nextCycle();
        checkOutput("ebreak_core_en", {31'd0, core_en}, 32'd0);
        nextCycle();
        checkOutput("halt1_state", {29'd0, state}, 32'd4);
        checkOutput("halt1_cause", {30'd0, halt_cause}, 32'd1);
        checkOutput("halt1_instret", instret, 32'd2);
        checkOutput("halt1_x2", xreg[2], 32'd8);
        checkOutput("halt1_pc", pc, 32'd8);

        // single step over the halted EBREAK
        applyStimulus(1'b0, 32'd0, 1'b0, 4'b0100);
        nextCycle();
        applyStimulus(1'b0, 32'd0, 1'b0, 4'b0000);
        checkOutput("step_state", {29'd0, state}, 32'd3);
        checkOutput("step_core_en", {31'd0, core_en}, 32'd1);
        nextCycle();
        checkOutput("step_back_state", {29'd0, state}, 32'd4);
        checkOutput("step_instret", instret, 32'd3);
        checkOutput("step_cause", {30'd0, halt_cause}, 32'd1);
        checkOutput("step_pc", pc, 32'd12);

        // reload a second image
        applyStimulus(1'b0, 32'd0, 1'b0, 4'b1000);
        nextCycle();
        applyStimulus(1'b0, 32'd0, 1'b0, 4'b0000);
        checkOutput("reload_state", {29'd0, state}, 32'd0);
        checkOutput("reload_core_rst", {31'd0, core_rst}, 32'd1);
        checkOutput("reload_cause", {30'd0, halt_cause}, 32'd0);
        loadWord(I_EBREAK, 1'b0, 8'd0, "rl0");
        loadWord(I_NOP, 1'b0, 8'd1, "rl1");
        loadWord(I_EBREAK, 1'b0, 8'd2, "rl2");
        loadWord(I_JAL0, 1'b1, 8'd3, "rl3");
        applyStimulus(1'b0, 32'd0, 1'b0, 4'b0000);
        checkOutput("rl_rel_state", {29'd0, state}, 32'd1);
        nextCycle();

        // halt_req collides with EBREAK on the first RUN cycle
        applyStimulus(1'b0, 32'd0, 1'b0, 4'b0010);
        checkOutput("coll_core_en", {31'd0, core_en}, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 32'd0, 1'b0, 4'b0000);
        checkOutput("coll_state", {29'd0, state}, 32'd4);
        checkOutput("coll_cause", {30'd0, halt_cause}, 32'd1);
        checkOutput("coll_instret", instret, 32'd3);

        // resume skips the EBREAK, then the next EBREAK halts
        applyStimulus(1'b0, 32'd0, 1'b0, 4'b0001);
        nextCycle();
        applyStimulus(1'b0, 32'd0, 1'b0, 4'b0000);
        checkOutput("resume_state", {29'd0, state}, 32'd2);
        checkOutput("resume_core_en", {31'd0, core_en}, 32'd1);
        nextCycle();
        checkOutput("resume_instret", instret, 32'd4);
        checkOutput("resume_pc", pc, 32'd4);
        nextCycle();
        checkOutput("ebreak2_core_en", {31'd0, core_en}, 32'd0);
        nextCycle();
        checkOutput("halt2_state", {29'd0, state}, 32'd4);
        checkOutput("halt2_instret", instret, 32'd5);

        // step onto the jal loop, run, then external halt
        applyStimulus(1'b0, 32'd0, 1'b0, 4'b0100);
        nextCycle();
        applyStimulus(1'b0, 32'd0, 1'b0, 4'b0000);
        nextCycle();
        checkOutput("step2_instret", instret, 32'd6);
        applyStimulus(1'b0, 32'd0, 1'b0, 4'b0001);
        nextCycle();
        applyStimulus(1'b0, 32'd0, 1'b0, 4'b0000);
        nextCycle();
        applyStimulus(1'b0, 32'd0, 1'b0, 4'b0010);
        checkOutput("hreq_core_en", {31'd0, core_en}, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 32'd0, 1'b0, 4'b0000);
        checkOutput("hreq_state", {29'd0, state}, 32'd4);
        checkOutput("hreq_cause", {30'd0, halt_cause}, 32'd2);
        checkOutput("hreq_instret", instret, 32'd7);

        // reset while running
        applyStimulus(1'b0, 32'd0, 1'b0, 4'b0001);
        nextCycle();
        applyStimulus(1'b0, 32'd0, 1'b0, 4'b0000);
        nextCycle();
        checkOutput("prerst_state", {29'd0, state}, 32'd2);
        rst = 1'b1;
        nextCycle();
        checkOutput("midrst_state", {29'd0, state}, 32'd0);
        checkOutput("midrst_instret", instret, 32'd0);
        checkOutput("midrst_core_rst", {31'd0, core_rst}, 32'd1);
        rst = 1'b0;

        // single-word jal image for the watchdog
        loadWord(I_JAL0, 1'b1, 8'd0, "wd0");
        applyStimulus(1'b0, 32'd0, 1'b0, 4'b0000);
        nextCycle();
`ifdef CORE_WDT_EN
        repeat (15) nextCycle();
        checkOutput("wdt_core_en", {31'd0, core_en}, 32'd0);
        nextCycle();
        checkOutput("wdt_state", {29'd0, state}, 32'd4);
        checkOutput("wdt_cause", {30'd0, halt_cause}, 32'd3);
        checkOutput("wdt_instret", instret, 32'd15);
`else
        repeat (1000) nextCycle();
        checkOutput("nowdt_state", {29'd0, state}, 32'd2);
        checkOutput("nowdt_cause", {30'd0, halt_cause}, 32'd0);
        checkOutput("nowdt_instret", instret, 32'd1000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
